im_boot_ctrl: RTL and testbench

IM_BOOT_CTRL -- requirements
Module: im_boot_ctrl

---
 rtl/im_boot_ctrl_pkg.sv | 19 +
 rtl/im_boot_ctrl_if.sv | 19 +
 rtl/im_boot_ctrl.sv | 107 ++++++++++
 tb/tb_im_boot_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/im_boot_ctrl_pkg.sv
// im_boot_ctrl_pkg
//   Shared definitions for the instruction-memory boot loader: the load FSM
//   state encoding and the default memory geometry.
package im_boot_ctrl_pkg;

    localparam int DEFAULT_DEPTH  = 2048;  // instruction memory depth, 16-bit words
    localparam int DEFAULT_ADDR_W = 16;    // memory address port width

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CNT_HI,
        ST_CNT_LO,
        ST_W_HI,
        ST_W_LO,
        ST_WRITE,
        ST_RUN
    } boot_state_t;

endpackage

// File: rtl/im_boot_ctrl_if.sv
// im_boot_ctrl_if
//   Instruction-memory port driven by the boot controller.
//   Signals:
//     im_addr   ADDR_W  address to instruction memory
//     im_rd_en  1       read enable
//     im_wr_en  1       write enable
//     im_wdata  16      write data
//   Modports: master (controller side, drives), slave (memory side, receives).
interface im_boot_ctrl_if #(
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] im_addr;
    logic              im_rd_en;
    logic              im_wr_en;
    logic [15:0]       im_wdata;

    modport master (output im_addr, output im_rd_en, output im_wr_en, output im_wdata);
    modport slave  (input  im_addr, input  im_rd_en, input  im_wr_en, input  im_wdata);
endinterface

// File: rtl/im_boot_ctrl.sv
// im_boot_ctrl
//   Loads a program into instruction memory from a serial byte stream, then
//   hands the memory port to the processor.
//   Stream format: 16-bit word count (MSB first), then count 16-bit words
//   (MSB first). Words beyond DEPTH are consumed but not written and set
//   the sticky ovf_err flag.
//   Ports:
//     clk, rst             clock, asynchronous active-high reset
//     boot_req             one-cycle pulse, (re)starts a load
//     ld_vld, ld_byte      received byte strobe and data
//     cpu_addr, cpu_rd_en  processor fetch request (passed through in RUN)
//     im                   instruction-memory port (master modport)
//     cpu_hold             holds the processor while not in RUN
//     boot_done            high while in RUN
//     ovf_err              sticky load-overflow flag
module im_boot_ctrl
    import im_boot_ctrl_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 boot_req,
    input  logic                 ld_vld,
    input  logic [7:0]           ld_byte,
    input  logic [ADDR_W-1:0]    cpu_addr,
    input  logic                 cpu_rd_en,
    im_boot_ctrl_if.master       im,
    output logic                 cpu_hold,
    output logic                 boot_done,
    output logic                 ovf_err
);

    // One extra bit so the write pointer can hold DEPTH itself (saturation).
    localparam logic [ADDR_W:0] DEPTH_P = (ADDR_W+1)'(DEPTH);

    boot_state_t     state, state_nxt;
    logic [7:0]      count_hi;
    logic [15:0]     remaining;
    logic [ADDR_W:0] wr_ptr;
    logic [15:0]     wbuf;
    logic            run_q;
    logic            wr_q;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   state_nxt = ST_IDLE;
            ST_CNT_HI: if (ld_vld) state_nxt = ST_CNT_LO;
            ST_CNT_LO: if (ld_vld) state_nxt = ({count_hi, ld_byte} == 16'd0) ? ST_RUN : ST_W_HI;
            ST_W_HI:   if (ld_vld) state_nxt = ST_W_LO;
            ST_W_LO:   if (ld_vld) state_nxt = ST_WRITE;
            ST_WRITE:  state_nxt = (remaining == 16'd1) ? ST_RUN : ST_W_HI;
            ST_RUN:    state_nxt = ST_RUN;
            default:   state_nxt = ST_IDLE;
        endcase
        if (boot_req) state_nxt = ST_CNT_HI;
    end

    // run_q / wr_q are decoded from the next state so they are valid for the
    // whole cycle spent in RUN / WRITE. wr_ptr does not change on entry to
    // WRITE, so its current value decides whether that write is in range.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            count_hi  <= '0;
            remaining <= '0;
            wr_ptr    <= '0;
            wbuf      <= '0;
            ovf_err   <= 1'b0;
            run_q     <= 1'b0;
            wr_q      <= 1'b0;
        end else begin
            state <= state_nxt;
            run_q <= (state_nxt == ST_RUN);
            wr_q  <= (state_nxt == ST_WRITE) && (wr_ptr < DEPTH_P);
            if (boot_req) begin
                ovf_err <= 1'b0;
            end else begin
                case (state)
                    ST_CNT_HI: if (ld_vld) count_hi <= ld_byte;
                    ST_CNT_LO: if (ld_vld) begin
                        remaining <= {count_hi, ld_byte};
                        wr_ptr    <= '0;
                    end
                    ST_W_HI:   if (ld_vld) wbuf[15:8] <= ld_byte;
                    ST_W_LO:   if (ld_vld) wbuf[7:0]  <= ld_byte;
                    ST_WRITE: begin
                        remaining <= remaining - 16'd1;
                        if (wr_ptr < DEPTH_P) wr_ptr  <= wr_ptr + 1'b1;
                        else                  ovf_err <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign im.im_addr  = run_q ? cpu_addr : wr_ptr[ADDR_W-1:0];
    assign im.im_rd_en = run_q & cpu_rd_en;
    assign im.im_wr_en = wr_q;
    assign im.im_wdata = wbuf;
    assign cpu_hold    = ~run_q;
    assign boot_done   = run_q;

endmodule

// File: tb/tb_im_boot_ctrl.sv
module tb_im_boot_ctrl;
    import im_boot_ctrl_pkg::*;

    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          boot_req = 1'b0;
    logic          ld_vld = 1'b0;
    logic [7:0]    ld_byte = '0;
    logic [AW-1:0] cpu_addr = '0;
    logic          cpu_rd_en = 1'b0;
    logic          cpu_hold, boot_done, ovf_err;

    im_boot_ctrl_if #(.ADDR_W(AW)) im ();

    im_boot_ctrl #(.DEPTH(4), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .boot_req  (boot_req),
        .ld_vld    (ld_vld),
        .ld_byte   (ld_byte),
        .cpu_addr  (cpu_addr),
        .cpu_rd_en (cpu_rd_en),
        .im        (im),
        .cpu_hold  (cpu_hold),
        .boot_done (boot_done),
        .ovf_err   (ovf_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [15:0]   data;
    } wr_t;
    wr_t exp_q[$];

    // Write monitor: every memory write must match the next expected write.
    always @(negedge clk) begin
        if (im.im_wr_en === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%h data=%h required=no write", im.im_addr, im.im_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (im.im_addr !== e.addr || im.im_wdata !== e.data) begin
                    errors++;
                    $display("FAIL write addr=%h data=%h required addr=%h data=%h",
                             im.im_addr, im.im_wdata, e.addr, e.data);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        ld_vld  = 1'b1;
        ld_byte = b;
        tick();
        ld_vld  = 1'b0;
        tick();
        tick();
    endtask

    task automatic boot();
        boot_req = 1'b1;
        tick();
        boot_req = 1'b0;
    endtask

    task automatic expect_wr(input logic [AW-1:0] a, input logic [15:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    initial begin
        logic [7:0] seq1 [8] = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01};
        logic [15:0] ovw [6] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666};

        // Reset values while rst is held
        #12;
        chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("rst_boot_done", 32'(boot_done), 32'd0);
        chk("rst_rd_en", 32'(im.im_rd_en), 32'd0);
        chk("rst_wr_en", 32'(im.im_wr_en), 32'd0);
        chk("rst_addr", 32'(im.im_addr), 32'd0);
        chk("rst_wdata", 32'(im.im_wdata), 32'd0);
        chk("rst_ovf", 32'(ovf_err), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        send_byte(8'h55);  // ignored in IDLE
        chk("idle_hold", 32'(cpu_hold), 32'd1);

        // Basic three-word load
        expect_wr(16'h0000, 16'h1234);
        expect_wr(16'h0001, 16'hABCD);
        expect_wr(16'h0002, 16'h0001);
        boot();
        chk("load_hold", 32'(cpu_hold), 32'd1);
        chk("load_done", 32'(boot_done), 32'd0);
        for (int i = 0; i < 8; i++) send_byte(seq1[i]);
        chk("run_done", 32'(boot_done), 32'd1);
        chk("run_hold", 32'(cpu_hold), 32'd0);
        chk("run_ovf", 32'(ovf_err), 32'd0);

        // RUN pass-through, same cycle
        cpu_addr = 16'h0001;
        cpu_rd_en = 1'b1;
        #1;
        chk("pass_addr", 32'(im.im_addr), 32'h0001);
        chk("pass_rd", 32'(im.im_rd_en), 32'd1);
        cpu_addr = 16'hBEE3;
        cpu_rd_en = 1'b0;
        #1;
        chk("pass_addr2", 32'(im.im_addr), 32'hBEE3);
        chk("pass_rd2", 32'(im.im_rd_en), 32'd0);
        send_byte(8'h12);  // ignored in RUN
        send_byte(8'h34);
        chk("run_stays", 32'(boot_done), 32'd1);

        // Zero-length load
        boot();
        chk("zero_hold", 32'(cpu_hold), 32'd1);
        chk("zero_rd_masked", 32'(im.im_rd_en), 32'd0);
        send_byte(8'h00);
        send_byte(8'h00);
        chk("zero_done", 32'(boot_done), 32'd1);

        // Overflow: six words into DEPTH=4
        for (int i = 0; i < 4; i++) expect_wr(16'(i), ovw[i]);
        boot();
        send_byte(8'h00);
        send_byte(8'h06);
        for (int i = 0; i < 6; i++) begin
            send_byte(ovw[i][15:8]);
            send_byte(ovw[i][7:0]);
            if (i == 3) chk("ovf_not_yet", 32'(ovf_err), 32'd0);
            if (i == 4) chk("ovf_set", 32'(ovf_err), 32'd1);
        end
        chk("ovf_final", 32'(ovf_err), 32'd1);
        chk("ovf_done", 32'(boot_done), 32'd1);

        // Restart mid-load clears ovf_err and abandons partial load
        boot();
        chk("ovf_cleared", 32'(ovf_err), 32'd0);
        send_byte(8'h00);
        send_byte(8'h03);
        send_byte(8'h77);
        expect_wr(16'h0000, 16'hBEEF);
        boot();
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'hBE);
        send_byte(8'hEF);
        chk("restart_done", 32'(boot_done), 32'd1);
        chk("restart_ovf", 32'(ovf_err), 32'd0);

        // Async reset while in W_LO
        boot();
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h12);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_hold", 32'(cpu_hold), 32'd1);
        chk("arst_wr_en", 32'(im.im_wr_en), 32'd0);
        chk("arst_addr", 32'(im.im_addr), 32'd0);
        chk("arst_wdata", 32'(im.im_wdata), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        send_byte(8'h34);  // would complete the word if not in IDLE
        tick();
        chk("arst_idle_hold", 32'(cpu_hold), 32'd1);
        chk("arst_idle_done", 32'(boot_done), 32'd0);

        tick();
        chk("pending_writes", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
